// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus front end: FSM state encoding and
// the fixed bit/stage counts used by the synchronizer and byte receiver.
package i2c_pkg;

    localparam int SYNC_STAGES   = 2;
    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RX     = 2'd1,
        ACK    = 2'd2,
        IGNORE = 2'd3
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_frontend_if.sv
// Bus-side signal bundle of the I2C front end.
// Handshake: rx_valid is a one-cycle pulse with no backpressure; rx_byte and
// rx_first are stable in the rx_valid cycle and held until the next pulse.
// bus_start/bus_stop are one-cycle event pulses; busy is a level.
interface i2c_bus_frontend_if;

    logic       scl_in;
    logic       sda_in;
    logic       ack_en;
    logic       sda_oe;
    logic       bus_start;
    logic       bus_stop;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_first;
    logic       busy;

    // Bus / testbench side: drives the raw lines and the accept decision.
    modport master (
        output scl_in, sda_in, ack_en,
        input  sda_oe, bus_start, bus_stop, rx_valid, rx_byte, rx_first, busy
    );

    // Front-end side.
    modport slave (
        input  scl_in, sda_in, ack_en,
        output sda_oe, bus_start, bus_stop, rx_valid, rx_byte, rx_first, busy
    );

endinterface

// File: rtl/i2c_signal_sync.sv
// Brings one raw bus line into the clk domain: SYNC_STAGES-flop synchronizer,
// optionally followed by a glitch filter enabled by I2C_FRONTEND_GLITCH_FILTER_EN.
// All flops reset to 1 so the line looks idle-high out of reset.
module i2c_signal_sync
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

`ifdef I2C_FRONTEND_GLITCH_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    // Metastability chain; the oldest stage is the usable sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_ON && (FILTER_LEN > 0)) begin : g_filter
            localparam int CNT_W = $clog2(FILTER_LEN + 1);
            logic [CNT_W-1:0] cnt_q;
            logic             level_q;

            // Follow the sample only after FILTER_LEN consecutive differing samples.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q   <= '0;
                    level_q <= 1'b1;
                end else if (s == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                    level_q <= s;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign q = level_q;
        end else begin : g_direct
            assign q = s;
        end
    endgenerate

endmodule

// File: rtl/i2c_bus_frontend.sv
// I2C slave-side bus front end: synchronizes SCL/SDA, detects START/STOP,
// deserializes bytes MSB first and drives the ACK bit when ack_en accepts.
// Optional glitch filter on both lines: I2C_FRONTEND_GLITCH_FILTER_EN.
module i2c_bus_frontend
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    i2c_bus_frontend_if.slave    bus,
    output i2c_state_t           state_dbg
);

    localparam logic [3:0] BYTE_CNT = 4'(BITS_PER_BYTE);

    logic scl_f, sda_f;
    logic scl_d, sda_d;
    logic scl_rise, scl_fall;
    logic start_det, stop_det;

    i2c_state_t                 state_q;
    logic [3:0]                 bit_cnt_q;
    logic [BITS_PER_BYTE-1:0]   shift_q;
    logic                       first_q;

    i2c_signal_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.scl_in),
        .q       (scl_f)
    );

    i2c_signal_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.sda_in),
        .q       (sda_f)
    );

    // Previous filtered levels, used for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    // START/STOP need SCL high in both this and the previous sample, so a
    // simultaneous SCL/SDA change is only ever treated as a clock/data edge.
    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = sda_d & ~sda_f & scl_f & scl_d;
    assign stop_det  = ~sda_d & sda_f & scl_f & scl_d;

    // Receive FSM with registered outputs; STOP beats START beats bit traffic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            first_q       <= 1'b0;
            bus.sda_oe    <= 1'b0;
            bus.bus_start <= 1'b0;
            bus.bus_stop  <= 1'b0;
            bus.rx_valid  <= 1'b0;
            bus.rx_first  <= 1'b0;
            bus.rx_byte   <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.bus_start <= 1'b0;
            bus.bus_stop  <= 1'b0;
            bus.rx_valid  <= 1'b0;
            if (stop_det && (state_q != IDLE)) begin
                state_q      <= IDLE;
                bus.bus_stop <= 1'b1;
                bus.sda_oe   <= 1'b0;
                bus.busy     <= 1'b0;
                bit_cnt_q    <= '0;
                shift_q      <= '0;
                first_q      <= 1'b0;
            end else if (start_det) begin
                state_q       <= RX;
                bus.bus_start <= 1'b1;
                bus.busy      <= 1'b1;
                bus.sda_oe    <= 1'b0;
                bit_cnt_q     <= '0;
                shift_q       <= '0;
                first_q       <= 1'b1;
            end else begin
                case (state_q)
                    RX: begin
                        if (bit_cnt_q < BYTE_CNT) begin
                            if (scl_rise) begin
                                shift_q   <= {shift_q[BITS_PER_BYTE-2:0], sda_f};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                                if (bit_cnt_q == BYTE_CNT - 4'd1) begin
                                    bus.rx_byte  <= {shift_q[BITS_PER_BYTE-2:0], sda_f};
                                    bus.rx_valid <= 1'b1;
                                    bus.rx_first <= first_q;
                                    first_q      <= 1'b0;
                                end
                            end
                        end else if (scl_fall) begin
                            // ACK decision point: SCL just dropped after bit 8.
                            if (bus.ack_en) begin
                                state_q    <= ACK;
                                bus.sda_oe <= 1'b1;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                    end
                    ACK: begin
                        if (scl_fall) begin
                            state_q    <= RX;
                            bus.sda_oe <= 1'b0;
                            bit_cnt_q  <= '0;
                        end
                    end
                    default: begin
                        // IDLE and IGNORE only react to START/STOP.
                    end
                endcase
            end
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Directed bench for i2c_bus_frontend: bit-banged I2C master, expected-event
// queue consumed by a monitor, plus direct level checks at key points.
module tb_i2c_bus_frontend;
    import i2c_pkg::*;

    localparam int PH = 10;
    localparam int W  = 11;
    localparam logic [1:0] K_START = 2'd0;
    localparam logic [1:0] K_STOP  = 2'd1;
    localparam logic [1:0] K_RX    = 2'd2;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m   = 1'b1;
    logic       sda_m   = 1'b1;
    i2c_state_t state_dbg;

    logic [W-1:0] exp_q[$];
    int n_vec      = 0;
    int n_err      = 0;
    int oe_cycles  = 0;

    i2c_bus_frontend_if bus();

    i2c_bus_frontend #(.FILTER_LEN(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and open-drain bus model: the DUT's ACK drive pulls SDA low.
    always #5 clk = ~clk;
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    function automatic logic [W-1:0] rx_word(input logic first, input logic [7:0] b);
        return {K_RX, first, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every DUT event must match the head of exp_q.
    always @(negedge clk) begin
        logic [W-1:0] act;
        if (reset_n && (bus.bus_start || bus.bus_stop || bus.rx_valid)) begin
            if (bus.rx_valid)       act = {K_RX, bus.rx_first, bus.rx_byte};
            else if (bus.bus_start) act = {K_START, 9'd0};
            else                    act = {K_STOP, 9'd0};
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_event: got %0h expected none", act);
            end else begin
                check("event", 32'(act), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (bus.sda_oe === 1'b1) oe_cycles++;
    end

    // Driver tasks: all bus changes on the falling clk edge.
    task automatic wait_ph();
        repeat (PH) @(negedge clk);
    endtask

    task automatic do_start();
        exp_q.push_back({K_START, 9'd0});
        sda_m = 1'b1; wait_ph();
        scl_m = 1'b1; wait_ph();
        sda_m = 1'b0; wait_ph();
        scl_m = 1'b0; wait_ph();
    endtask

    task automatic do_stop();
        exp_q.push_back({K_STOP, 9'd0});
        sda_m = 1'b0; wait_ph();
        scl_m = 1'b1; wait_ph();
        sda_m = 1'b1; wait_ph();
        wait_ph();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_ph();
        scl_m = 1'b1; wait_ph(); wait_ph();
        scl_m = 1'b0; wait_ph();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic ack_slot();
        send_bit(1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sda_oe"},   32'(bus.sda_oe),    32'd0);
        check({tag, "_start"},    32'(bus.bus_start), 32'd0);
        check({tag, "_stop"},     32'(bus.bus_stop),  32'd0);
        check({tag, "_rx_valid"}, 32'(bus.rx_valid),  32'd0);
        check({tag, "_rx_first"}, 32'(bus.rx_first),  32'd0);
        check({tag, "_busy"},     32'(bus.busy),      32'd0);
        check({tag, "_rx_byte"},  32'(bus.rx_byte),   32'd0);
        check({tag, "_state"},    32'(state_dbg),     32'(IDLE));
    endtask

    initial begin
        bus.ack_en = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset");

        // Byte 0xAB accepted, then 0x3C refused, then 0xFF ignored until STOP.
        do_start();
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("state_after_start", 32'(state_dbg), 32'(RX));
        bus.ack_en = 1'b1;
        oe_cycles = 0;
        exp_q.push_back(rx_word(1'b1, 8'hAB));
        send_byte(8'hAB);
        ack_slot();
        check("ack_window_cycles", 32'(oe_cycles), 32'(4 * PH));
        check("state_after_ack", 32'(state_dbg), 32'(RX));
        bus.ack_en = 1'b0;
        oe_cycles = 0;
        exp_q.push_back(rx_word(1'b0, 8'h3C));
        send_byte(8'h3C);
        ack_slot();
        check("nack_oe_cycles", 32'(oe_cycles), 32'd0);
        check("state_after_nack", 32'(state_dbg), 32'(IGNORE));
        send_byte(8'hFF);
        do_stop();
        check("busy_after_stop", 32'(bus.busy), 32'd0);
        check("state_after_stop", 32'(state_dbg), 32'(IDLE));
        check("rx_byte_held_3c", 32'(bus.rx_byte), 32'h3C);

        // Partial byte cut by repeated START, then 0x7E.
        do_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        do_start();
        bus.ack_en = 1'b1;
        exp_q.push_back(rx_word(1'b1, 8'h7E));
        send_byte(8'h7E);
        ack_slot();
        bus.ack_en = 1'b0;
        do_stop();
        check("rx_byte_7e", 32'(bus.rx_byte), 32'h7E);

        // STOP after 5 bits: no byte, rx_byte untouched.
        do_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        do_stop();
        check("state_stop_5bits", 32'(state_dbg), 32'(IDLE));
        check("rx_byte_after_5bits", 32'(bus.rx_byte), 32'h7E);
        check("busy_stop_5bits", 32'(bus.busy), 32'd0);

        // One-clock SCL glitch with SDA high just after START.
        do_start();
        sda_m = 1'b1; wait_ph();
        scl_m = 1'b1; @(negedge clk);
        scl_m = 1'b0; wait_ph();
`ifdef I2C_FRONTEND_GLITCH_FILTER_EN
        exp_q.push_back(rx_word(1'b1, 8'h55));
`else
        exp_q.push_back(rx_word(1'b1, 8'hAA));
`endif
        send_byte(8'h55);
        ack_slot();
        check("state_after_glitch", 32'(state_dbg), 32'(IGNORE));
        do_stop();

        // Reset asserted while the ACK bit is being driven.
        do_start();
        bus.ack_en = 1'b1;
        exp_q.push_back(rx_word(1'b1, 8'h5A));
        send_byte(8'h5A);
        sda_m = 1'b1; wait_ph();
        scl_m = 1'b1; wait_ph();
        check("oe_in_ack", 32'(bus.sda_oe), 32'd1);
        check("state_in_ack", 32'(state_dbg), 32'(ACK));
        #2 reset_n = 1'b0;
        #1 check("oe_async_release", 32'(bus.sda_oe), 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        bus.ack_en = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * PH) @(negedge clk);
        check_idle_outputs("post_reset");

        wait_ph();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_bus_frontend.md
I2C_BUS_FRONTEND -- requirements
Module: i2c_bus_frontend

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 3: number of consecutive equal synchronized samples required before a filtered SCL/SDA level changes.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port scl_in  input  1  raw bus SCL, asynchronous to clk.
REQ-005 SHALL have port sda_in  input  1  raw bus SDA, asynchronous to clk.
REQ-006 SHALL have port ack_en  input  1  downstream peripheral accepts the current byte; sampled at the ACK decision point.
REQ-007 SHALL have port sda_oe  output  1  1 = pull SDA low (ACK drive); pad logic holds SDA output data at 0.
REQ-008 SHALL have port bus_start  output  1  one-cycle pulse on START or repeated START.
REQ-009 SHALL have port bus_stop  output  1  one-cycle pulse on STOP.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse; rx_byte holds a complete byte.
REQ-011 SHALL have port rx_byte  output  8  last received byte, MSB first on the wire; held until the next rx_valid.
REQ-012 SHALL have port rx_first  output  1  qualifies rx_valid: byte is the first after (repeated) START, i.e. address+R/W.
REQ-013 SHALL have port busy  output  1  high from START until STOP.

Function
REQ-014 SHALL pass scl_in and sda_in each through a 2-flop synchronizer, then the optional filter (REQ-030), giving scl_f and sda_f.
REQ-015 SHALL detect START as an sda_f 1->0 transition while scl_f is 1 and stable; STOP as an sda_f 0->1 transition while scl_f is 1 and stable.
REQ-016 SHALL treat a scl_f and sda_f change in the same cycle as a data/clock edge only, never as START/STOP.
REQ-017 SHALL implement states IDLE, RX, ACK, IGNORE.
REQ-018 IDLE: on START -> RX; bit_cnt = 0; first-byte flag = 1; bus_start pulses; busy = 1.
REQ-019 RX: on each scl_f rising edge SHALL shift sda_f into an 8-bit shift register (MSB first) and increment bit_cnt.
REQ-020 On the 8th rising edge SHALL, on the next clk edge, load rx_byte, pulse rx_valid, drive rx_first = first-byte flag, then clear the first-byte flag.
REQ-021 At the scl_f falling edge after the 8th bit SHALL sample ack_en: 1 -> ACK with sda_oe = 1; 0 -> IGNORE with sda_oe = 0 (NACK).
REQ-022 ACK: sda_oe SHALL stay 1 until the next scl_f falling edge (end of 9th clock), then go 0; bit_cnt = 0; -> RX.
REQ-023 IGNORE: SHALL shift nothing and pulse no rx_valid until START or STOP.
REQ-024 START in RX/ACK/IGNORE (repeated START) SHALL pulse bus_start, clear sda_oe, bit_cnt = 0, first-byte flag = 1, -> RX; partial byte discarded.
REQ-025 STOP in any non-IDLE state SHALL pulse bus_stop, clear sda_oe and busy, discard partial byte, -> IDLE.
REQ-026 bit_cnt SHALL be 4 bits, never exceed 8, and never wrap.
REQ-027 Latency: rx_valid SHALL be asserted exactly 1 clk after the cycle in which scl_f rises for bit 8.

Reset
REQ-028 On reset_n low, asynchronously: state = IDLE; sda_oe, bus_start, bus_stop, rx_valid, rx_first, busy = 0; rx_byte = 8'h00; shift register, bit_cnt = 0; synchronizer and filter flops = 1 (bus idle high).
REQ-029 Reset in mid-ACK SHALL release sda_oe immediately, without waiting for clk.

Configuration
REQ-030 I2C_FRONTEND_GLITCH_FILTER_EN defined: scl_f/sda_f change only after FILTER_LEN consecutive equal synchronized samples (+FILTER_LEN cycles latency); undefined: scl_f/sda_f are the 2-flop synchronizer outputs directly, and FILTER_LEN is ignored.

Structure
REQ-031 Shared package i2c_pkg SHALL hold the state encoding (IDLE, RX, ACK, IGNORE), SYNC_STAGES = 2, and BITS_PER_BYTE = 8.
REQ-032 Sub-module i2c_signal_sync (synchronizer + optional filter) SHALL be instantiated once each for SCL and SDA.

Verification
REQ-033 START, bits 0xAB, ack_en = 1 -> rx_valid with rx_byte = 0xAB, rx_first = 1; sda_oe high for exactly the 9th SCL period.
REQ-034 Second byte 0x3C, ack_en = 0 -> rx_byte = 0x3C, rx_first = 0, sda_oe stays 0; further bits 0xFF ignored until STOP -> bus_stop, busy = 0.
REQ-035 START, 3 bits, repeated START, byte 0x7E -> two bus_start pulses, no rx_valid for the partial byte, rx_byte = 0x7E, rx_first = 1.
REQ-036 STOP after 5 bits -> bus_stop, state IDLE, no rx_valid, rx_byte unchanged.
REQ-037 With the macro and FILTER_LEN = 3, a 1-clk SCL glitch high -> no bit shifted; without the macro, the same glitch shifts one bit.
REQ-038 reset_n low during ACK -> sda_oe = 0 before the next clk edge; after release, all outputs at reset values, state IDLE.
